lcd_responder: RTL and testbench
================================

// Module: lcd_responder
//
// PURPOSE
// - Device-side end of the Niski HD44780-style LCD bus (RS, RW, E, DATA[7:0]).
// - Decodes the commands the SoC's LCD driver issues and holds a 2x16 DDRAM.
// - Emulates the busy flag with timed execution.
// - Answers status/data reads and exposes the character buffer on a read port
//   for an on-chip display renderer; also serves as a synthesizable bus model
//   for system tests.
//
// PARAMETERS
// SYNC_STAGES   2      synchronizer depth on lcd_rs/rw/e/data_in (>=2)
// BUSY_CYCLES   1850   busy duration for a normal command or data write/read (>=1)
// CLEAR_CYCLES  76000  busy duration for clear display / return home, after any fill (>=1)
//
// PORTS
// clk           in   1  system clock
// rst_n         in   1  asynchronous, active-low reset
// lcd_rs        in   1  0 = instruction/status, 1 = data
// lcd_rw        in   1  0 = write, 1 = read
// lcd_e         in   1  enable strobe, asynchronous to clk
// lcd_data_in   in   8  bus data driven by host
// lcd_data_out  out  8  bus data driven by this block during reads
// lcd_data_oe   out  1  drive enable for lcd_data_out
// disp_addr     in   5  {line, col[3:0]} renderer read address
// disp_char     out  8  DDRAM[disp_addr], 1-cycle latency
// display_on    out  1  display-control D bit
// cursor_on     out  1  display-control C bit
// blink_on      out  1  display-control B bit
// cursor_addr   out  5  current address counter {line, col}
// busy          out  1  internal busy flag (same as status BF)
// protocol_err  out  1  sticky; set when a write/data-read arrives while busy
//
// BEHAVIOUR
// - Reset values:
//   - lcd_data_out=0, lcd_data_oe=0, display/cursor/blink=0.
//   - AC=0, I/D=1 (increment), protocol_err=0.
//   - busy=1; FSM starts in CLEAR.
// - Inputs pass SYNC_STAGES flops. Edges of E are detected on the synced signal.
// - Write: on a synced E falling edge with RW=0, capture RS/DATA.
// - Read:
//   - On a synced E rising edge with RW=1, latch the read word and set oe=1.
//   - oe returns to 0 on the E falling edge.
//   - A data read advances AC at the falling edge.
// - Status read (RS=0, RW=1):
//   - Returns {busy, line, 2'b00, col}.
//   - Always allowed and never sets busy.
// - FSM states: IDLE, EXEC, CLEAR.
//   - IDLE --accepted cmd--> EXEC; counter is loaded with BUSY_CYCLES.
//   - IDLE --0x01--> CLEAR.
//   - EXEC: counter decrements to 0, then goes to IDLE. 0x02 loads CLEAR_CYCLES.
//   - CLEAR:
//     - Writes 0x20 to cells 0..31, one per cycle (32 cycles).
//     - Then AC=0 and I/D=1.
//     - Then goes to EXEC with CLEAR_CYCLES.
//   - busy=1 in every state except IDLE.
// - Command decode (RS=0, RW=0), highest set bit wins:
//   - 1xxxxxxx: set DDRAM address. line=d[6], col=d[3:0]; d[5:4] ignored.
//   - 01xxxxxx: CGRAM address. No-op but busy.
//   - 001xxxxx: function set. No-op but busy.
//   - 0001xxxx: shift. No-op but busy.
//   - 00001DCB: display control.
//   - 000001IS: entry mode. S is ignored.
//   - 0000001x: home. AC=0, busy for CLEAR_CYCLES.
//   - 00000001: clear.
//   - 0x00: no-op, not busy.
// - Data write (RS=1, RW=0): DDRAM[AC]<=data, then AC advances.
// - AC advance:
//   - Increment wraps 0x0F->0x10 ({1,0}) and 0x1F->0x00.
//   - Decrement is the inverse.
// - While busy:
//   - Writes and data reads are ignored and set protocol_err.
//   - A data read still drives oe with the old cell value, without advancing AC.
// - Renderer read and bus write to the same cell in the same cycle: disp_char
//   returns the old value (read-before-write).
// - A second E edge before the first command completes counts as "while busy".
// - Reset asserted mid-command or mid-clear:
//   - Aborts immediately and asynchronously forces the reset values.
//   - The fill restarts after release.
//
// STRUCTURE
// - Package niski_lcd_pkg holds:
//   - the FSM state enum (IDLE/EXEC/CLEAR);
//   - command opcode mask constants;
//   - LCD_COLS=16, LCD_LINES=2, BLANK_CHAR=8'h20.
// - Sub-module lcd_ddram: 32x8 RAM with one sync read/write port (bus/fill) and
//   one sync read-only port (renderer).
// - Synchronizer, edge detect, decoder, FSM and AC logic live in lcd_responder.
//
// TESTING
// 1. Reset release -> busy=1 for 32+CLEAR_CYCLES cycles; then all 32 cells read
//    0x20 and status read = 8'h00.
// 2. Write 0x0F, then "AB" as data -> display/cursor/blink=1; DDRAM[0]=0x41,
//    DDRAM[1]=0x42; status = 8'h82 during busy, then 8'h02.
// 3. Set address 0xCF, data write 0x5A, then 0x5B -> cell 31=0x5A and cell 0=0x5B.
//    Repeat with entry mode 0x04 from 0xC0 -> next write lands at cell 15.
// 4. Data write while busy -> cell unchanged, AC unchanged, protocol_err=1 and
//    held until reset.
// 5. Data read at AC=1 after test 2 -> oe=1 while E high, data=0x42; AC=2 after
//    the falling edge.
// 6. rst_n pulsed low mid-clear (cell 10 being filled) -> outputs immediately at
//    reset values; fill restarts from cell 0. Concurrent disp_addr sweep matches
//    a bench model.

Source files
------------

// File: rtl/niski_lcd_pkg.sv
// Shared types and constants for the Niski HD44780-style LCD responder.
package niski_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } lcd_state_t;

  localparam int LCD_COLS  = 16;
  localparam int LCD_LINES = 2;
  localparam int LCD_CELLS = LCD_COLS * LCD_LINES;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Instruction opcodes: the highest set bit selects the command.
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  // {line, col} wraps 0x0F->0x10 and 0x1F->0x00, which is plain 5-bit arithmetic.
  function automatic logic [4:0] ac_step(input logic [4:0] ac, input logic inc);
    return inc ? (ac + 5'd1) : (ac - 5'd1);
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display RAM: one read/write port for bus and fill, one read-only port for the renderer.
module lcd_ddram
  import niski_lcd_pkg::*;
(
  input  logic       clk,
  input  logic [4:0] a_addr,
  input  logic       a_we,
  input  logic [7:0] a_wdata,
  output logic [7:0] a_rdata,
  input  logic [4:0] b_addr,
  output logic [7:0] b_rdata
);

  logic [7:0] mem [LCD_CELLS];

  // Both reads sample the array before this edge's write (read-before-write).
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/lcd_responder.sv
// Device side of the LCD bus: synchronizes the host strobes, decodes commands,
// emulates the busy flag and owns the DDRAM address counter.
module lcd_responder
  import niski_lcd_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [4:0] cursor_addr,
  output logic       busy,
  output logic       protocol_err
);

  localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
  localparam logic [4:0]    FILL_LAST  = 5'(LCD_CELLS - 1);

  logic [10:0] sync_reg [SYNC_STAGES];
  logic        rs_s, rw_s, e_s, e_prev_reg;
  logic [7:0]  data_s;
  logic        e_rise, e_fall;

  lcd_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]  fill_reg, fill_next;
  logic [4:0]  ac_reg, ac_next;
  logic        id_reg, id_next;
  logic        display_reg, display_next;
  logic        cursor_reg, cursor_next;
  logic        blink_reg, blink_next;
  logic        err_reg, err_next;
  logic        oe_reg, oe_next;
  logic [7:0]  dout_reg, dout_next;

  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        busy_int;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= '0;
        else        sync_reg[gi] <= {lcd_rs, lcd_rw, lcd_e, lcd_data_in};
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= '0;
        else        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign {rs_s, rw_s, e_s, data_s} = sync_reg[SYNC_STAGES-1];
  assign e_rise   = e_s & ~e_prev_reg;
  assign e_fall   = ~e_s & e_prev_reg;
  assign busy_int = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_prev_reg  <= 1'b0;
      state_reg   <= ST_CLEAR;
      cnt_reg     <= '0;
      fill_reg    <= '0;
      ac_reg      <= '0;
      id_reg      <= 1'b1;
      display_reg <= 1'b0;
      cursor_reg  <= 1'b0;
      blink_reg   <= 1'b0;
      err_reg     <= 1'b0;
      oe_reg      <= 1'b0;
      dout_reg    <= '0;
    end else begin
      e_prev_reg  <= e_s;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fill_reg    <= fill_next;
      ac_reg      <= ac_next;
      id_reg      <= id_next;
      display_reg <= display_next;
      cursor_reg  <= cursor_next;
      blink_reg   <= blink_next;
      err_reg     <= err_next;
      oe_reg      <= oe_next;
      dout_reg    <= dout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    fill_next    = fill_reg;
    ac_next      = ac_reg;
    id_next      = id_reg;
    display_next = display_reg;
    cursor_next  = cursor_reg;
    blink_next   = blink_reg;
    err_next     = err_reg;
    oe_next      = oe_reg;
    dout_next    = dout_reg;
    ram_we       = 1'b0;
    ram_addr     = ac_reg;
    ram_wdata    = data_s;

    case (state_reg)
      ST_EXEC: begin
        if (cnt_reg <= CW'(1)) state_next = ST_IDLE;
        else                   cnt_next   = cnt_reg - CW'(1);
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = fill_reg;
        ram_wdata = BLANK_CHAR;
        if (fill_reg == FILL_LAST) begin
          fill_next  = '0;
          ac_next    = '0;
          id_next    = 1'b1;
          state_next = ST_EXEC;
          cnt_next   = CLEAR_LOAD;
        end else begin
          fill_next = fill_reg + 5'd1;
        end
      end
      default: ;
    endcase

    // Reads latch their word on the rising edge; status reads never touch the FSM.
    if (e_rise && rw_s) begin
      oe_next   = 1'b1;
      dout_next = rs_s ? ram_rdata : {busy_int, ac_reg[4], 2'b00, ac_reg[3:0]};
    end

    // Every write-side state change happens only from IDLE, so it never races the fill above.
    if (e_fall) begin
      if (rw_s) begin
        oe_next = 1'b0;
        if (rs_s) begin
          if (busy_int) begin
            err_next = 1'b1;
          end else begin
            ac_next    = ac_step(ac_reg, id_reg);
            state_next = ST_EXEC;
            cnt_next   = BUSY_LOAD;
          end
        end
      end else if (busy_int) begin
        err_next = 1'b1;
      end else if (rs_s) begin
        ram_we     = 1'b1;
        ram_addr   = ac_reg;
        ram_wdata  = data_s;
        ac_next    = ac_step(ac_reg, id_reg);
        state_next = ST_EXEC;
        cnt_next   = BUSY_LOAD;
      end else if ((data_s & CMD_SET_DDRAM) != 8'h00) begin
        ac_next    = {data_s[6], data_s[3:0]};
        state_next = ST_EXEC;
        cnt_next   = BUSY_LOAD;
      end else if ((data_s & (CMD_SET_CGRAM | CMD_FUNC_SET | CMD_SHIFT)) != 8'h00) begin
        state_next = ST_EXEC;
        cnt_next   = BUSY_LOAD;
      end else if ((data_s & CMD_DISP_CTRL) != 8'h00) begin
        display_next = data_s[2];
        cursor_next  = data_s[1];
        blink_next   = data_s[0];
        state_next   = ST_EXEC;
        cnt_next     = BUSY_LOAD;
      end else if ((data_s & CMD_ENTRY) != 8'h00) begin
        id_next    = data_s[1];
        state_next = ST_EXEC;
        cnt_next   = BUSY_LOAD;
      end else if ((data_s & CMD_HOME) != 8'h00) begin
        ac_next    = '0;
        state_next = ST_EXEC;
        cnt_next   = CLEAR_LOAD;
      end else if ((data_s & CMD_CLEAR) != 8'h00) begin
        fill_next  = '0;
        state_next = ST_CLEAR;
      end
    end
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .a_addr  (ram_addr),
    .a_we    (ram_we),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_addr  (disp_addr),
    .b_rdata (disp_char)
  );

  assign lcd_data_out = dout_reg;
  assign lcd_data_oe  = oe_reg;
  assign display_on   = display_reg;
  assign cursor_on    = cursor_reg;
  assign blink_on     = blink_reg;
  assign cursor_addr  = ac_reg;
  assign busy         = busy_int;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus transactions with hand-computed expectations.
module tb_lcd_responder;

  localparam int BSY = 40;
  localparam int CLR = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] disp_addr;
  logic [7:0] disp_char;
  logic       display_on, cursor_on, blink_on;
  logic [4:0] cursor_addr;
  logic       busy, protocol_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_mem [32];

  always #5 clk = ~clk;

  lcd_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(BSY), .CLEAR_CYCLES(CLR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .disp_addr    (disp_addr),
    .disp_char    (disp_char),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .cursor_addr  (cursor_addr),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] write rs=%0b data=%02h ac=%02h busy=%0b", rs, d, cursor_addr, busy);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe_hi, output logic oe_lo);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1;
    @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    d = lcd_data_out; oe_hi = lcd_data_oe;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    oe_lo = lcd_data_oe;
    lcd_rw = 1'b0;
    $display("[TB] read  rs=%0b data=%02h oe=%0b/%0b ac=%02h", rs, d, oe_hi, oe_lo, cursor_addr);
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    disp_addr = a;
    @(negedge clk);
    d = disp_char;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oh, ol;
    rst_n = 1'b0; lcd_rs = 0; lcd_rw = 0; lcd_e = 0; lcd_data_in = 0; disp_addr = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({lcd_data_oe, lcd_data_out, display_on, cursor_on, blink_on, cursor_addr, busy, protocol_err}
        !== {1'b0, 8'h00, 3'b000, 5'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_vals: oe=%0b dout=%02h dcb=%0b%0b%0b ac=%02h busy=%0b err=%0b, want 0 00 000 00 1 0",
               lcd_data_oe, lcd_data_out, display_on, cursor_on, blink_on, cursor_addr, busy, protocol_err);
    end
    rst_n = 1'b1;
    repeat (31 + CLR) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_hold: got %0b want 1", busy); end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_release: got %0b want 0", busy); end
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), d);
      exp_mem[i] = 8'h20;
      tests_run++;
      if (d !== 8'h20) begin tests_failed++; $display("FAIL blank_cell[%0d]: got %02h want 20", i, d); end
    end
    bus_read(1'b0, d, oh, ol);
    tests_run++;
    if (d !== 8'h00 || oh !== 1'b1 || ol !== 1'b0) begin
      tests_failed++;
      $display("FAIL status_after_reset: got %02h oe=%0b/%0b want 00 oe=1/0", d, oh, ol);
    end
  endtask

  task automatic test_display_ab();
    logic [7:0] d;
    logic oh, ol;
    bit ok;
    bus_write(1'b0, 8'h0F); wait_idle(ok);
    tests_run++;
    if (!ok || {display_on, cursor_on, blink_on} !== 3'b111) begin
      tests_failed++; $display("FAIL disp_ctrl: got dcb=%0b%0b%0b ok=%0b want 111", display_on, cursor_on, blink_on, ok);
    end
    bus_write(1'b1, 8'h41); wait_idle(ok);
    exp_mem[0] = 8'h41;
    bus_write(1'b1, 8'h42);
    exp_mem[1] = 8'h42;
    bus_read(1'b0, d, oh, ol);
    tests_run++;
    if (d !== 8'h82) begin tests_failed++; $display("FAIL status_busy: got %02h want 82", d); end
    wait_idle(ok);
    bus_read(1'b0, d, oh, ol);
    tests_run++;
    if (!ok || d !== 8'h02) begin tests_failed++; $display("FAIL status_idle: got %02h want 02", d); end
    read_cell(5'd0, d);
    tests_run++;
    if (d !== 8'h41) begin tests_failed++; $display("FAIL cell0_A: got %02h want 41", d); end
    read_cell(5'd1, d);
    tests_run++;
    if (d !== 8'h42) begin tests_failed++; $display("FAIL cell1_B: got %02h want 42", d); end
    tests_run++;
    if (protocol_err !== 1'b0) begin tests_failed++; $display("FAIL err_clean: got %0b want 0", protocol_err); end
  endtask

  task automatic test_data_read();
    logic [7:0] d;
    logic oh, ol;
    bit ok;
    bus_write(1'b0, 8'h81); wait_idle(ok);
    bus_read(1'b1, d, oh, ol);
    tests_run++;
    if (d !== 8'h42 || oh !== 1'b1 || ol !== 1'b0) begin
      tests_failed++; $display("FAIL data_read: got %02h oe=%0b/%0b want 42 oe=1/0", d, oh, ol);
    end
    tests_run++;
    if (cursor_addr !== 5'h02) begin tests_failed++; $display("FAIL read_advance: got ac=%02h want 02", cursor_addr); end
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    bit ok;
    bus_write(1'b0, 8'hCF); wait_idle(ok);
    tests_run++;
    if (cursor_addr !== 5'h1F) begin tests_failed++; $display("FAIL set_addr_cf: got ac=%02h want 1f", cursor_addr); end
    bus_write(1'b1, 8'h5A); wait_idle(ok); exp_mem[31] = 8'h5A;
    bus_write(1'b1, 8'h5B); wait_idle(ok); exp_mem[0]  = 8'h5B;
    read_cell(5'd31, d);
    tests_run++;
    if (d !== 8'h5A) begin tests_failed++; $display("FAIL cell31: got %02h want 5a", d); end
    read_cell(5'd0, d);
    tests_run++;
    if (d !== 8'h5B) begin tests_failed++; $display("FAIL cell0_wrap: got %02h want 5b", d); end
    tests_run++;
    if (cursor_addr !== 5'h01) begin tests_failed++; $display("FAIL ac_wrap_inc: got %02h want 01", cursor_addr); end
    bus_write(1'b0, 8'h04); wait_idle(ok);
    bus_write(1'b0, 8'hC0); wait_idle(ok);
    bus_write(1'b1, 8'h33); wait_idle(ok); exp_mem[16] = 8'h33;
    bus_write(1'b1, 8'h34); wait_idle(ok); exp_mem[15] = 8'h34;
    read_cell(5'd15, d);
    tests_run++;
    if (d !== 8'h34) begin tests_failed++; $display("FAIL cell15_dec: got %02h want 34", d); end
    read_cell(5'd16, d);
    tests_run++;
    if (d !== 8'h33) begin tests_failed++; $display("FAIL cell16_dec: got %02h want 33", d); end
    tests_run++;
    if (cursor_addr !== 5'h0E) begin tests_failed++; $display("FAIL ac_dec: got %02h want 0e", cursor_addr); end
    bus_write(1'b0, 8'h06); wait_idle(ok);
  endtask

  task automatic test_busy_write();
    logic [7:0] d;
    logic oh, ol;
    bit ok;
    bus_write(1'b0, 8'h85); wait_idle(ok);
    bus_write(1'b1, 8'h61); exp_mem[5] = 8'h61;
    bus_write(1'b1, 8'h62);
    tests_run++;
    if (protocol_err !== 1'b1 || cursor_addr !== 5'h06) begin
      tests_failed++; $display("FAIL busy_write: err=%0b ac=%02h want err=1 ac=06", protocol_err, cursor_addr);
    end
    wait_idle(ok);
    read_cell(5'd6, d);
    tests_run++;
    if (d !== 8'h20) begin tests_failed++; $display("FAIL busy_cell_unchanged: got %02h want 20", d); end
    bus_write(1'b1, 8'h63); exp_mem[6] = 8'h63;
    bus_read(1'b1, d, oh, ol);
    tests_run++;
    if (d !== 8'h20 || oh !== 1'b1 || cursor_addr !== 5'h07) begin
      tests_failed++; $display("FAIL busy_read: got %02h oe=%0b ac=%02h want 20 oe=1 ac=07", d, oh, cursor_addr);
    end
    wait_idle(ok);
    tests_run++;
    if (protocol_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %0b want 1", protocol_err); end
    read_cell(5'd6, d);
    tests_run++;
    if (d !== 8'h63) begin tests_failed++; $display("FAIL cell6_write: got %02h want 63", d); end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] d;
    bit ok, seen;
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h01;
    @(negedge clk); lcd_e = 1'b1;
    repeat (4) @(negedge clk); lcd_e = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL clear_start: busy=%0b want 1 within 20 cycles", busy); end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) exp_mem[i] = 8'h20;
    #1;
    tests_run++;
    if ({lcd_data_oe, display_on, cursor_on, blink_on, cursor_addr, busy, protocol_err}
        !== {1'b0, 3'b000, 5'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: oe=%0b dcb=%0b%0b%0b ac=%02h busy=%0b err=%0b want 0 000 00 1 0",
               lcd_data_oe, display_on, cursor_on, blink_on, cursor_addr, busy, protocol_err);
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), d);
      tests_run++;
      if (d !== exp_mem[i]) begin tests_failed++; $display("FAIL sweep_mid[%0d]: got %02h want %02h", i, d, exp_mem[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL refill_timeout: busy=%0b want 0", busy); end
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), d);
      tests_run++;
      if (d !== 8'h20) begin tests_failed++; $display("FAIL sweep_refill[%0d]: got %02h want 20", i, d); end
    end
  endtask

  initial begin
    test_reset();
    test_display_ab();
    test_data_read();
    test_wrap();
    test_busy_write();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
